tile_instr_sequencer: RTL and testbench

- Upstream stage of each CGRA tile.
- Holds a small per-tile program (configuration) memory and streams 64-bit instructions into the tile's instruction input.
- Supports looped execution, valid/ready back-pressure from the tile, and abort.
- While not issuing, it drives an all-zero instruction (opcode bit 0 = 0, so the tile ALU is disabled).

---
 rtl/cgra_pkg.sv | 31 +++
 rtl/tile_cfg_mem.sv | 26 ++
 rtl/tile_instr_sequencer.sv | 145 ++++++++++++++
 tb/tb_tile_instr_sequencer.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/cgra_pkg.sv
// Shared CGRA definitions: instruction field layout, idle instruction, sequencer states.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package cgra_pkg;

  localparam int INSTR_W = 64;

  // Instruction field bounds
  localparam int OPC_MSB   = 6;
  localparam int OPC_LSB   = 0;
  localparam int RD_MSB    = 11;
  localparam int RD_LSB    = 7;
  localparam int FUNCT_MSB = 14;
  localparam int FUNCT_LSB = 12;
  localparam int RS1_MSB   = 19;
  localparam int RS1_LSB   = 15;
  localparam int RS2_MSB   = 24;
  localparam int RS2_LSB   = 20;
  localparam int DATA_MSB  = 63;
  localparam int DATA_LSB  = 32;

  // Opcode bit 0 clear keeps the tile ALU disabled.
  localparam logic [INSTR_W-1:0] NOP_INSTR = 64'h0;

  typedef enum logic [1:0] {
    SEQ_IDLE,
    SEQ_RUN,
    SEQ_DONE
  } seq_state_t;

endpackage

// File: rtl/tile_cfg_mem.sv
// Per-tile program memory: DEPTH x INSTR_W, synchronous write, asynchronous read, no reset.
// Latency: write visible on the read port the cycle after the write edge; read is combinational.
// Backpressure: none; the caller gates we.
// Ports: clk, we/waddr/wdata (write port), raddr/rdata (read port).
module tile_cfg_mem #(
  parameter int DEPTH   = 16,
  parameter int AW      = 4,
  parameter int INSTR_W = 64
) (
  input  logic               clk,
  input  logic               we,
  input  logic [AW-1:0]      waddr,
  input  logic [INSTR_W-1:0] wdata,
  input  logic [AW-1:0]      raddr,
  output logic [INSTR_W-1:0] rdata
);

  logic [INSTR_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/tile_instr_sequencer.sv
// Streams a looped program from the tile config memory into the tile's instruction input.
// Latency: first instruction registered on the cycle after an accepted start; 1 instr/cycle after.
// Backpressure: instr_out/pc held stable while instr_valid=1 and instr_ready=0; abort beats handshake.
// Ports: clk, rst (async active-low); cfg_we/cfg_addr/cfg_data program writes (IDLE only);
//        start/prog_len/loop_count launch; abort; instr_out/instr_valid/instr_ready to tile;
//        busy, done/err pulses, pc, iter status.
module tile_instr_sequencer
  import cgra_pkg::*;
#(
  parameter int DEPTH   = 16,
  parameter int AW      = 4,
  parameter int INSTR_W = cgra_pkg::INSTR_W,
  parameter int LOOP_W  = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               cfg_we,
  input  logic [AW-1:0]      cfg_addr,
  input  logic [INSTR_W-1:0] cfg_data,
  input  logic               start,
  input  logic [AW:0]        prog_len,
  input  logic [LOOP_W-1:0]  loop_count,
  input  logic               abort,
  output logic [INSTR_W-1:0] instr_out,
  output logic               instr_valid,
  input  logic               instr_ready,
  output logic               busy,
  output logic               done,
  output logic               err,
  output logic [AW-1:0]      pc,
  output logic [LOOP_W-1:0]  iter
);

  localparam logic [AW:0] LEN_ONE   = (AW+1)'(1);
  localparam logic [AW:0] LEN_DEPTH = (AW+1)'(DEPTH);

  seq_state_t         state;
  logic [AW:0]        len_q;
  logic [LOOP_W-1:0]  loops_q;

  logic               mem_we;
  logic [AW-1:0]      rd_addr;
  logic [INSTR_W-1:0] mem_rdata;
  logic [INSTR_W-1:0] rd_instr;
  logic               last;
  logic               len_ok;
  logic               hs;
  logic [LOOP_W-1:0]  iter_nxt;

  // Memory is write-protected outside IDLE.
  assign mem_we   = cfg_we && (state == SEQ_IDLE);
  assign last     = ({1'b0, pc} == (len_q - LEN_ONE));
  assign len_ok   = (prog_len != '0) && (prog_len <= LEN_DEPTH);
  assign hs       = instr_valid && instr_ready;
  assign iter_nxt = iter + LOOP_W'(1);

  // Next instruction to load: slot 0 on start or wrap, otherwise pc+1.
  assign rd_addr = (state == SEQ_RUN && !last) ? pc + AW'(1) : '0;

  tile_cfg_mem #(
    .DEPTH   (DEPTH),
    .AW      (AW),
    .INSTR_W (INSTR_W)
  ) u_cfg_mem (
    .clk   (clk),
    .we    (mem_we),
    .waddr (cfg_addr),
    .wdata (cfg_data),
    .raddr (rd_addr),
    .rdata (mem_rdata)
  );

  // A write landing on the same edge as start must already be seen as the
  // first issued instruction, so forward it past the asynchronous read.
  assign rd_instr = (mem_we && cfg_addr == rd_addr) ? cfg_data : mem_rdata;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= SEQ_IDLE;
      len_q       <= '0;
      loops_q     <= '0;
      instr_out   <= '0;
      instr_valid <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      err         <= 1'b0;
      pc          <= '0;
      iter        <= '0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      case (state)
        SEQ_IDLE: begin
          if (start) begin
            if (len_ok) begin
              len_q       <= prog_len;
              loops_q     <= loop_count;
              pc          <= '0;
              iter        <= '0;
              state       <= SEQ_RUN;
              instr_valid <= 1'b1;
              instr_out   <= rd_instr;
              busy        <= 1'b1;
            end else begin
              err <= 1'b1;
            end
          end
        end
        SEQ_RUN: begin
          if (abort) begin
            // pc and iter deliberately keep their last values.
            state       <= SEQ_IDLE;
            instr_valid <= 1'b0;
            instr_out   <= INSTR_W'(NOP_INSTR);
            busy        <= 1'b0;
          end else if (hs) begin
            if (!last) begin
              pc        <= pc + AW'(1);
              instr_out <= rd_instr;
            end else begin
              pc   <= '0;
              iter <= iter_nxt;
              if (loops_q != '0 && iter_nxt == loops_q) begin
                state       <= SEQ_DONE;
                instr_valid <= 1'b0;
                instr_out   <= INSTR_W'(NOP_INSTR);
                busy        <= 1'b0;
                done        <= 1'b1;
              end else begin
                instr_out <= rd_instr;
              end
            end
          end
        end
        SEQ_DONE: begin
          state <= SEQ_IDLE;
        end
        default: begin
          state <= SEQ_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_tile_instr_sequencer.sv
// Self-checking bench: directed scenarios plus random traffic against a handshake-count model.
// Latency: n/a.
// Backpressure: instr_ready driven from fixed patterns and $urandom.
module tb_tile_instr_sequencer;

  logic        clk;
  logic        rst;
  logic        cfg_we;
  logic [3:0]  cfg_addr;
  logic [63:0] cfg_data;
  logic        start;
  logic [4:0]  prog_len;
  logic [7:0]  loop_count;
  logic        abort;
  logic [63:0] instr_out;
  logic        instr_valid;
  logic        instr_ready;
  logic        busy;
  logic        done;
  logic        err;
  logic [3:0]  pc;
  logic [7:0]  iter;

  tile_instr_sequencer dut (
    .clk         (clk),
    .rst         (rst),
    .cfg_we      (cfg_we),
    .cfg_addr    (cfg_addr),
    .cfg_data    (cfg_data),
    .start       (start),
    .prog_len    (prog_len),
    .loop_count  (loop_count),
    .abort       (abort),
    .instr_out   (instr_out),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .busy        (busy),
    .done        (done),
    .err         (err),
    .pc          (pc),
    .iter        (iter)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: a run is described by the number of handshakes h taken
  // so far; everything visible follows from h, the program length and loops.
  int          mode;      // 0 idle, 1 running, 2 completion cycle
  logic [63:0] mmem [16];
  logic [63:0] snap [16];
  int          m_len;
  int          m_loops;
  int          h;
  int          pc_hold;
  int          iter_hold;
  bit          err_e;
  int          hs_cnt;
  int          done_cnt;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    mode      = 0;
    pc_hold   = 0;
    iter_hold = 0;
    err_e     = 0;
  endtask

  task automatic model_edge();
    int prev;
    prev  = mode;
    err_e = 0;
    if (!rst) return;
    if (prev == 0) begin
      if (cfg_we) mmem[cfg_addr] = cfg_data;
      if (start) begin
        if (prog_len >= 1 && prog_len <= 16) begin
          snap    = mmem;
          m_len   = int'(prog_len);
          m_loops = int'(loop_count);
          h       = 0;
          mode    = 1;
        end else begin
          err_e = 1;
        end
      end
    end else if (prev == 1) begin
      if (abort) begin
        pc_hold   = h % m_len;
        iter_hold = (h / m_len) % 256;
        mode      = 0;
      end else if (instr_ready) begin
        h++;
        if (m_loops != 0 && h == m_len * m_loops) mode = 2;
      end
    end else begin
      pc_hold   = 0;
      iter_hold = m_loops;
      mode      = 0;
    end
  endtask

  task automatic compare_all();
    logic [63:0] e_out;
    int e_pc, e_iter;
    e_out = '0;
    if (mode == 1) begin
      e_out  = snap[h % m_len];
      e_pc   = h % m_len;
      e_iter = (h / m_len) % 256;
    end else if (mode == 2) begin
      e_pc   = 0;
      e_iter = m_loops;
    end else begin
      e_pc   = pc_hold;
      e_iter = iter_hold;
    end
    chk("instr_valid", 64'(instr_valid), 64'(mode == 1));
    chk("instr_out",   instr_out,        e_out);
    chk("busy",        64'(busy),        64'(mode == 1));
    chk("done",        64'(done),        64'(mode == 2));
    chk("err",         64'(err),         64'(err_e));
    chk("pc",          64'(pc),          64'(e_pc));
    chk("iter",        64'(iter),        64'(e_iter));
  endtask

  // One clock: inputs already driven, update model at the edge, check 1ns later.
  task automatic step();
    if (instr_valid && instr_ready) hs_cnt++;
    @(posedge clk);
    model_edge();
    #1;
    if (done) done_cnt++;
    compare_all();
  endtask

  task automatic quiet();
    cfg_we = 0; cfg_addr = '0; cfg_data = '0;
    start = 0; prog_len = '0; loop_count = '0;
    abort = 0; instr_ready = 1;
  endtask

  task automatic launch(input int len, input int loops);
    start = 1; prog_len = 5'(len); loop_count = 8'(loops);
    step();
    start = 0;
  endtask

  initial begin
    rst = 0;
    quiet();
    model_reset();
    for (int i = 0; i < 16; i++) mmem[i] = '0;
    #1;
    compare_all();
    step();
    step();
    rst = 1;

    // Fill every slot so the model and memory agree from the start.
    for (int i = 0; i < 16; i++) begin
      cfg_we = 1; cfg_addr = 4'(i);
      cfg_data = (i == 0) ? 64'h11 : (i == 1) ? 64'h22 : (i == 2) ? 64'h33 : {$urandom, $urandom};
      step();
    end
    quiet();

    // Straight run, ready held high.
    done_cnt = 0;
    launch(3, 2);
    chk("t1_first", instr_out, 64'h11);
    for (int i = 0; i < 8; i++) step();
    chk("t1_done_pulses", 64'(done_cnt), 64'd1);
    chk("t1_iter", 64'(iter), 64'd2);

    // Ready pattern 1,0,0,1 repeating.
    hs_cnt = 0;
    launch(3, 2);
    for (int i = 0; i < 20; i++) begin
      instr_ready = (i % 4 == 0) || (i % 4 == 3);
      step();
    end
    instr_ready = 1;
    chk("t2_handshakes", 64'(hs_cnt), 64'd6);

    // Illegal lengths.
    launch(0, 1);
    chk("t3_err_len0", 64'(err), 64'd1);
    step();
    launch(17, 1);
    chk("t3_err_len17", 64'(err), 64'd1);
    chk("t3_valid", 64'(instr_valid), 64'd0);
    step();

    // Endless single-slot loop, iter wraps, then abort.
    cfg_we = 1; cfg_addr = 0; cfg_data = 64'hA5;
    step();
    cfg_we = 0;
    launch(1, 0);
    for (int i = 0; i < 300; i++) step();
    abort = 1;
    step();
    abort = 0;
    chk("t4_abort_out", instr_out, 64'h0);
    for (int i = 0; i < 3; i++) step();

    // Write to slot 0 together with start; writes and start during run ignored.
    cfg_we = 1; cfg_addr = 0; cfg_data = 64'h77;
    launch(3, 2);
    cfg_we = 0;
    chk("t5_fwd_slot0", instr_out, 64'h77);
    step();
    cfg_we = 1; cfg_addr = 1; cfg_data = 64'hFF;
    start = 1; prog_len = 5'd1; loop_count = 8'd0;
    step();
    quiet();
    for (int i = 0; i < 8; i++) step();

    // Asynchronous reset mid-run.
    launch(3, 0);
    step();
    @(posedge clk);
    model_edge();
    #3;
    rst = 0;
    #1;
    model_reset();
    compare_all();
    step();
    #2;
    rst = 1;
    for (int i = 0; i < 4; i++) step();

    // Random traffic.
    for (int i = 0; i < 3000; i++) begin
      cfg_we      = ($urandom_range(0, 3) == 0);
      cfg_addr    = 4'($urandom);
      cfg_data    = {$urandom, $urandom};
      start       = ($urandom_range(0, 7) == 0);
      prog_len    = ($urandom_range(0, 9) == 0) ? 5'($urandom_range(17, 31)) : 5'($urandom_range(0, 16));
      loop_count  = 8'($urandom_range(0, 3));
      abort       = ($urandom_range(0, 29) == 0);
      instr_ready = ($urandom_range(0, 3) != 0);
      step();
    end
    quiet();
    step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
